// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter sharing one downstream resource among 8 requesters.
// Produces a registered one-hot grant plus its binary index (bit k -> index k).
// The owner keeps the grant until it releases, drops its request, or reaches
// the MAX_HOLD timeout (0 disables the timeout). Every grant end is followed
// by exactly one idle cycle before the next grant can appear.
// The release pulse input is named release_in because "release" is a reserved
// SystemVerilog keyword and cannot be used as a plain identifier.
module rr_encoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       release_in,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [7:0] MaxHoldCnt = 8'(MAX_HOLD);
    localparam logic       TimeoutEn  = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       preempt_q, preempt_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    logic       end_rel;
    logic       end_drop;
    logic       end_timeout;
    logic       grant_end;

    // Pick the first requester at or above ptr, wrapping from 7 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Decode the three ways a grant can end; preempt only for a pure timeout.
    always_comb begin
        end_rel     = release_in;
        end_drop    = !req[gnt_idx_q];
        end_timeout = TimeoutEn && (hold_cnt_q == MaxHoldCnt);
        grant_end   = (state_q == GRANT) && (end_rel || end_drop || end_timeout);
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    gnt_d       = 8'b1 << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 8'd0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    preempt_d   = end_timeout && !end_rel && !end_drop;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench for rr_encoder_arbiter: table of directed vectors plus
// hand-written sequences for timeout, timeout-disabled and mid-grant reset.
module tb_rr_encoder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;

    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    logic [7:0] gnt_z;
    logic [2:0] gnt_idx_z;
    logic       gnt_valid_z;
    logic       preempt_z;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        int         test_no;
        logic       do_rst;
        logic [7:0] req;
        logic       rel;
        logic [7:0] exp_gnt;
        logic [2:0] exp_idx;
        logic       exp_valid;
        logic       exp_pre;
    } vec_t;

    vec_t vecs[$];

    rr_encoder_arbiter #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .release_in (rel),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid),
        .preempt    (preempt)
    );

    rr_encoder_arbiter #(.MAX_HOLD(0)) dut_z (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .release_in (rel),
        .gnt        (gnt_z),
        .gnt_idx    (gnt_idx_z),
        .gnt_valid  (gnt_valid_z),
        .preempt    (preempt_z)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] rq, input logic rl);
        req = rq;
        rel = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        req   = 8'h00;
        rel   = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt", gnt, 8'h00);
        checkOutput("rst_idx", {5'd0, gnt_idx}, 8'h00);
        checkOutput("rst_valid", {7'd0, gnt_valid}, 8'h00);
        checkOutput("rst_preempt", {7'd0, preempt}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic void addVec(input int t, input logic r, input logic [7:0] rq,
                                   input logic rl, input logic v, input logic [2:0] ix,
                                   input logic p);
        vec_t x;
        x.test_no   = t;
        x.do_rst    = r;
        x.req       = rq;
        x.rel       = rl;
        x.exp_valid = v;
        x.exp_idx   = v ? ix : 3'd0;
        x.exp_gnt   = v ? (8'b1 << ix) : 8'h00;
        x.exp_pre   = p;
        vecs.push_back(x);
    endfunction

    // Structural invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        checkOutput("inv_onehot", {7'd0, $onehot0(gnt)}, 8'h01);
        checkOutput("inv_valid", {7'd0, gnt_valid}, {7'd0, gnt != 8'h00});
        checkOutput("inv_idx", gnt, gnt_valid ? (8'b1 << gnt_idx) : 8'h00);
        checkOutput("inv_z_onehot", {7'd0, $onehot0(gnt_z)}, 8'h01);
        checkOutput("inv_z_idx", gnt_z, gnt_valid_z ? (8'b1 << gnt_idx_z) : 8'h00);
        checkOutput("inv_z_preempt", {7'd0, preempt_z}, 8'h00);
    end

    initial begin
        int cnt;
        int guard;
        logic saw_pre;

        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;

        // Test 1: single requester, release after 3 grant cycles, re-grant after gap.
        addVec(1, 1, 8'h01, 0, 1, 0, 0);
        addVec(1, 0, 8'h01, 0, 1, 0, 0);
        addVec(1, 0, 8'h01, 0, 1, 0, 0);
        addVec(1, 0, 8'h01, 1, 0, 0, 0);
        addVec(1, 0, 8'h01, 0, 1, 0, 0);
        addVec(1, 0, 8'h00, 0, 0, 0, 0);
        // Test 2: all requesting, rotation 0..7 then 0 with a gap after each.
        for (int k = 0; k < 9; k++) begin
            addVec(2, (k == 0), 8'hFF, 0, 1, 3'(k % 8), 0);
            if (k < 8) addVec(2, 0, 8'hFF, 1, 0, 0, 0);
        end
        // Test 3: wrap from ptr=6 picks 0 before 5, then 5.
        addVec(3, 1, 8'h20, 0, 1, 5, 0);
        addVec(3, 0, 8'h20, 1, 0, 0, 0);
        addVec(3, 0, 8'h21, 0, 1, 0, 0);
        addVec(3, 0, 8'h21, 1, 0, 0, 0);
        addVec(3, 0, 8'h21, 0, 1, 5, 0);
        addVec(3, 0, 8'h21, 1, 0, 0, 0);
        // Test 5: drop plus release on the same edge, ptr=3 so idx 4 wins over 2.
        addVec(5, 1, 8'h04, 0, 1, 2, 0);
        addVec(5, 0, 8'h04, 0, 1, 2, 0);
        addVec(5, 0, 8'h10, 1, 0, 0, 0);
        addVec(5, 0, 8'h14, 0, 1, 4, 0);
        // Release coinciding with timeout: no preempt.
        addVec(7, 1, 8'h08, 0, 1, 3, 0);
        addVec(7, 0, 8'h08, 0, 1, 3, 0);
        addVec(7, 0, 8'h08, 0, 1, 3, 0);
        addVec(7, 0, 8'h08, 0, 1, 3, 0);
        addVec(7, 0, 8'h08, 1, 0, 0, 0);
        // Release while idle is ignored.
        addVec(8, 1, 8'h00, 1, 0, 0, 0);
        addVec(8, 0, 8'h02, 1, 1, 1, 0);
        addVec(8, 0, 8'h02, 0, 1, 1, 0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) doReset();
            applyStimulus(vecs[i].req, vecs[i].rel);
            checkOutput($sformatf("t%0d_v%0d_gnt", vecs[i].test_no, i), gnt, vecs[i].exp_gnt);
            checkOutput($sformatf("t%0d_v%0d_idx", vecs[i].test_no, i),
                        {5'd0, gnt_idx}, {5'd0, vecs[i].exp_idx});
            checkOutput($sformatf("t%0d_v%0d_valid", vecs[i].test_no, i),
                        {7'd0, gnt_valid}, {7'd0, vecs[i].exp_valid});
            checkOutput($sformatf("t%0d_v%0d_preempt", vecs[i].test_no, i),
                        {7'd0, preempt}, {7'd0, vecs[i].exp_pre});
        end

        // Test 4: timeout after exactly 4 cycles, preempt pulse, re-grant after gap.
        doReset();
        applyStimulus(8'h08, 0);
        cnt   = 0;
        guard = 0;
        while (gnt == 8'h08 && guard < 20) begin
            cnt++;
            guard++;
            applyStimulus(8'h08, 0);
        end
        checkOutput("t4_hold_cycles", 8'(cnt), 8'd4);
        checkOutput("t4_gnt_drop", gnt, 8'h00);
        checkOutput("t4_preempt", {7'd0, preempt}, 8'h01);
        checkOutput("t4_z_still_gnt", gnt_z, 8'h08);
        applyStimulus(8'h08, 0);
        checkOutput("t4_regrant", gnt, 8'h08);
        checkOutput("t4_preempt_clear", {7'd0, preempt}, 8'h00);

        // MAX_HOLD=0 instance keeps the grant indefinitely with no preempt.
        saw_pre = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(8'h08, 0);
            saw_pre = saw_pre | preempt_z;
        end
        checkOutput("z_long_hold", gnt_z, 8'h08);
        checkOutput("z_no_preempt", {7'd0, saw_pre}, 8'h00);

        // Test 6: async reset mid-grant clears outputs and ptr.
        doReset();
        applyStimulus(8'h40, 0);
        applyStimulus(8'h40, 1);
        applyStimulus(8'h40, 0);
        checkOutput("t6_pre_gnt", gnt, 8'h40);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_gnt", gnt, 8'h00);
        checkOutput("t6_async_idx", {5'd0, gnt_idx}, 8'h00);
        checkOutput("t6_async_valid", {7'd0, gnt_valid}, 8'h00);
        checkOutput("t6_async_preempt", {7'd0, preempt}, 8'h00);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'hC0, 0);
        checkOutput("t6_resume_gnt", gnt, 8'h40);
        checkOutput("t6_resume_idx", {5'd0, gnt_idx}, 8'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
